// File: rtl/renkon_linebuf.sv
// renkon_linebuf: raster-order line buffer feeding FSIZE x FSIZE windows
// to the renkon PE array, one window per valid convolution position.
module renkon_linebuf #(
    parameter int DWIDTH = 16,
    parameter int FSIZE  = 5,
    parameter int MAXIMG = 32,
    parameter int LWIDTH = $clog2(MAXIMG + 1)
) (
    input  logic                             clk,
    input  logic                             xrst,
    input  logic                             buf_req,
    input  logic [LWIDTH-1:0]                img_size,
    input  logic                             in_valid,
    input  logic [DWIDTH-1:0]                in_pixel,
    output logic                             buf_busy,
    output logic                             out_valid,
    output logic [FSIZE*FSIZE*DWIDTH-1:0]    out_window,
    output logic                             frame_done
);

    localparam int NL = FSIZE - 1;
    localparam int PW = (NL > 1) ? $clog2(NL) : 1;
    localparam int AW = (MAXIMG > 1) ? $clog2(MAXIMG) : 1;
    localparam logic [LWIDTH-1:0] LMIN  = LWIDTH'(FSIZE);
    localparam logic [LWIDTH-1:0] LMAX  = LWIDTH'(MAXIMG);
    localparam logic [LWIDTH-1:0] LEDGE = LWIDTH'(FSIZE - 1);
    localparam logic [LWIDTH-1:0] ONE   = LWIDTH'(1);
    localparam logic [PW:0]       LROWS = (PW + 1)'(NL);
    localparam logic [PW-1:0]     WPTOP = PW'(NL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [LWIDTH-1:0] n, row, col;
    logic [PW-1:0]     wp;
    logic [AW-1:0]     caddr;
    logic              start, accept, col_last, row_last, emit;

    logic [DWIDTH-1:0] mem  [NL][MAXIMG];
    logic [DWIDTH-1:0] win  [FSIZE][FSIZE];
    logic [DWIDTH-1:0] nwin [FSIZE][FSIZE];
    logic [DWIDTH-1:0] ncol [FSIZE];

    assign caddr    = col[AW-1:0];
    assign start    = (state == S_IDLE) && buf_req &&
                      (img_size >= LMIN) && (img_size <= LMAX);
    assign accept   = (state == S_RUN) && in_valid;
    assign col_last = (col == n - ONE);
    assign row_last = (row == n - ONE);
    assign emit     = accept && (row >= LEDGE) && (col >= LEDGE);

    assign buf_busy   = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (accept && col_last && row_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Slot wp holds the oldest stored row; walk forward from it.
    for (genvar k = 0; k < NL; k++) begin : g_col
        logic [PW:0]   sum;
        logic [PW-1:0] slot;
        assign sum     = {1'b0, wp} + (PW + 1)'(k);
        assign slot    = (sum >= LROWS) ? PW'(sum - LROWS) : sum[PW-1:0];
        assign ncol[k] = mem[slot][caddr];
    end
    assign ncol[FSIZE-1] = in_pixel;

    always_comb begin
        for (int r = 0; r < FSIZE; r++) begin
            for (int c = 0; c < FSIZE - 1; c++) nwin[r][c] = win[r][c+1];
            nwin[r][FSIZE-1] = ncol[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wp][caddr] <= in_pixel;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            n          <= '0;
            row        <= '0;
            col        <= '0;
            wp         <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            for (int r = 0; r < FSIZE; r++)
                for (int c = 0; c < FSIZE; c++) win[r][c] <= '0;
        end else begin
            out_valid <= emit;
            if (start) begin
                n   <= img_size;
                row <= '0;
                col <= '0;
                wp  <= '0;
            end else if (accept) begin
                for (int r = 0; r < FSIZE; r++)
                    for (int c = 0; c < FSIZE; c++) win[r][c] <= nwin[r][c];
                if (col_last) begin
                    col <= '0;
                    row <= row + ONE;
                    wp  <= (wp == WPTOP) ? '0 : wp + PW'(1);
                end else begin
                    col <= col + ONE;
                end
                if (emit) begin
                    for (int r = 0; r < FSIZE; r++)
                        for (int c = 0; c < FSIZE; c++)
                            out_window[(r*FSIZE+c)*DWIDTH +: DWIDTH] <= nwin[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_renkon_linebuf.sv
// tb_renkon_linebuf: randomized and directed frames against a window
// model built straight from the image array.
module tb_renkon_linebuf;

    localparam int DW   = 16;
    localparam int F    = 5;
    localparam int MAXI = 32;
    localparam int LW   = $clog2(MAXI + 1);
    localparam int WW   = F * F * DW;

    logic          clk = 1'b0;
    logic          xrst;
    logic          buf_req;
    logic [LW-1:0] img_size;
    logic          in_valid;
    logic [DW-1:0] in_pixel;
    logic          buf_busy;
    logic          out_valid;
    logic [WW-1:0] out_window;
    logic          frame_done;

    always #5 clk = ~clk;

    renkon_linebuf #(.DWIDTH(DW), .FSIZE(F), .MAXIMG(MAXI), .LWIDTH(LW)) dut (
        .clk(clk), .xrst(xrst), .buf_req(buf_req), .img_size(img_size),
        .in_valid(in_valid), .in_pixel(in_pixel), .buf_busy(buf_busy),
        .out_valid(out_valid), .out_window(out_window), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] img [MAXI][MAXI];
    logic [WW-1:0] obs[$];
    logic [WW-1:0] expq[$];
    bit            obs_done[$];
    int            gapviol, stray_done, first_acc, timeout;
    bit            seen_done;

    task automatic fill_img(input int n, input int base);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) img[r][c] = DW'(base + r * n + c);
    endtask

    task automatic fill_rand(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) img[r][c] = DW'($urandom);
    endtask

    task automatic build_exp(input int n);
        logic [WW-1:0] w;
        expq.delete();
        for (int r0 = 0; r0 <= n - F; r0++)
            for (int c0 = 0; c0 <= n - F; c0++) begin
                w = '0;
                for (int r = 0; r < F; r++)
                    for (int c = 0; c < F; c++)
                        w[(r*F+c)*DW +: DW] = img[r0+r][c0+c];
                expq.push_back(w);
            end
    endtask

    task automatic start_frame(input int n);
        in_valid = 1'b0;
        buf_req  = 1'b1;
        img_size = LW'(n);
        @(posedge clk); #1;
        buf_req  = 1'b0;
    endtask

    task automatic sample(input bit iv, input int sent);
        if (out_valid === 1'b1) begin
            obs.push_back(out_window);
            obs_done.push_back(frame_done === 1'b1);
            if (first_acc < 0) first_acc = sent;
            if (!iv) gapviol++;
        end else if (frame_done === 1'b1) begin
            stray_done++;
        end
        if (frame_done === 1'b1) seen_done = 1'b1;
    endtask

    // mode 0: continuous, 1: 1,0,0,1 pattern + row-5 gap, 2: random gaps
    task automatic run_frame(input int n, input int mode, input int stop_after);
        int sent, total, ph, g, cyc;
        bit iv;
        int pat[4];
        pat = '{1, 0, 0, 1};
        obs.delete();
        obs_done.delete();
        gapviol = 0; stray_done = 0; first_acc = -1; timeout = 0;
        seen_done = 1'b0;
        total = (stop_after >= 0) ? stop_after : n * n;
        sent = 0; ph = 0; g = 0; cyc = 0;
        while (sent < total && cyc < 4000) begin
            if (mode == 1 && sent == 5 * n && g < 3) begin
                iv = 1'b0;
                g++;
            end else if (mode == 1) begin
                iv = (pat[ph % 4] != 0);
                ph++;
            end else if (mode == 2) begin
                iv = ($urandom_range(2) != 0);
            end else begin
                iv = 1'b1;
            end
            in_valid = iv;
            in_pixel = iv ? img[sent / n][sent % n] : DW'($urandom);
            @(posedge clk); #1;
            if (iv) sent++;
            cyc++;
            sample(iv, sent);
            in_valid = 1'b0;
        end
        if (sent < total) timeout = 1;
        if (stop_after < 0) begin
            cyc = 0;
            while (!seen_done && cyc < 10) begin
                @(posedge clk); #1;
                sample(1'b0, sent);
                cyc++;
            end
            if (!seen_done) timeout = 1;
        end
    endtask

    task automatic test_reset;
        xrst = 1'b0; buf_req = 1'b0; img_size = '0;
        in_valid = 1'b0; in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", buf_busy); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (out_window !== '0) begin errors++;
            $display("FAIL reset_window: got %h want 0", out_window); end
        xrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [WW-1:0] w;
        int nd;
        fill_img(8, 1);
        build_exp(8);
        start_frame(8);
        checks++; if (buf_busy !== 1'b1) begin errors++;
            $display("FAIL basic_busy: got %b want 1", buf_busy); end
        run_frame(8, 0, -1);
        checks++; if (timeout != 0) begin errors++;
            $display("FAIL basic_timeout: got %0d want 0", timeout); end
        checks++; if (obs.size() != 16) begin errors++;
            $display("FAIL basic_count: got %0d want 16", obs.size()); end
        checks++; if (first_acc != 37) begin errors++;
            $display("FAIL basic_first_lat: pixels %0d want 37", first_acc); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin errors++;
                $display("FAIL basic_win%0d: got %h want %h", i, obs[i], expq[i]); end
        end
        if (obs.size() > 0) begin
            w = obs[0];
            checks++; if (w[0 +: DW] !== 16'd1 || w[4*DW +: DW] !== 16'd5 ||
                          w[20*DW +: DW] !== 16'd33 || w[24*DW +: DW] !== 16'd37) begin
                errors++;
                $display("FAIL basic_first_win: got %0d %0d %0d %0d want 1 5 33 37",
                    w[0 +: DW], w[4*DW +: DW], w[20*DW +: DW], w[24*DW +: DW]); end
            w = obs[obs.size()-1];
            checks++; if (w[24*DW +: DW] !== 16'd64) begin errors++;
                $display("FAIL basic_last_w44: got %0d want 64", w[24*DW +: DW]); end
        end
        nd = stray_done;
        foreach (obs_done[i]) if (obs_done[i]) nd++;
        checks++; if (nd != 1 || obs_done.size() == 0 || !obs_done[obs_done.size()-1]) begin
            errors++;
            $display("FAIL basic_done_align: dones %0d stray %0d want 1 on last", nd, stray_done); end
        @(posedge clk); #1;
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL basic_idle: got %b want 0", buf_busy); end
    endtask

    task automatic test_gaps;
        fill_img(8, 1);
        build_exp(8);
        start_frame(8);
        run_frame(8, 1, -1);
        checks++; if (timeout != 0) begin errors++;
            $display("FAIL gaps_timeout: got %0d want 0", timeout); end
        checks++; if (obs.size() != 16) begin errors++;
            $display("FAIL gaps_count: got %0d want 16", obs.size()); end
        checks++; if (gapviol != 0) begin errors++;
            $display("FAIL gaps_valid_after_gap: got %0d want 0", gapviol); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin errors++;
                $display("FAIL gaps_win%0d: got %h want %h", i, obs[i], expq[i]); end
        end
        checks++; if (stray_done != 0 || obs_done.size() == 0 || !obs_done[obs_done.size()-1]) begin
            errors++;
            $display("FAIL gaps_done_align: stray %0d want 0", stray_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        start_frame(4);
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL illegal4_busy: got %b want 0", buf_busy); end
        start_frame(33);
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL illegal33_busy: got %b want 0", buf_busy); end
        fill_img(8, 500);
        run_frame(8, 0, 12);
        checks++; if (obs.size() != 0 || stray_done != 0) begin errors++;
            $display("FAIL illegal_outputs: valids %0d dones %0d want 0 0", obs.size(), stray_done); end
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL illegal_busy_after: got %b want 0", buf_busy); end
    endtask

    task automatic test_min;
        fill_img(5, 1);
        build_exp(5);
        start_frame(5);
        run_frame(5, 0, -1);
        checks++; if (obs.size() != 1) begin errors++;
            $display("FAIL min_count: got %0d want 1", obs.size()); end
        if (obs.size() > 0) begin
            checks++; if (obs[0] !== expq[0]) begin errors++;
                $display("FAIL min_win: got %h want %h", obs[0], expq[0]); end
            checks++; if (!obs_done[0] || stray_done != 0) begin errors++;
                $display("FAIL min_done_align: got %0d stray %0d want 1 0", obs_done[0], stray_done); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midreset;
        fill_img(8, 1);
        start_frame(8);
        run_frame(8, 0, 20);
        xrst = 1'b0;
        #1;
        checks++; if (buf_busy !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: busy %b valid %b done %b want 0 0 0",
                buf_busy, out_valid, frame_done); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_window !== '0) begin errors++;
            $display("FAIL midreset_window: got %h want 0", out_window); end
        checks++; if (buf_busy !== 1'b0) begin errors++;
            $display("FAIL midreset_busy: got %b want 0", buf_busy); end
        xrst = 1'b1;
        @(posedge clk); #1;
        build_exp(8);
        start_frame(8);
        run_frame(8, 0, -1);
        checks++; if (obs.size() != 16 || timeout != 0) begin errors++;
            $display("FAIL midreset_count: got %0d want 16", obs.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin errors++;
                $display("FAIL midreset_win%0d: got %h want %h", i, obs[i], expq[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [WW-1:0] w;
        fill_img(8, 1);
        start_frame(8);
        run_frame(8, 0, -1);
        checks++; if (obs.size() != 16 || timeout != 0) begin errors++;
            $display("FAIL b2b_f1_count: got %0d want 16", obs.size()); end
        @(posedge clk); #1;
        fill_img(8, 100);
        build_exp(8);
        start_frame(8);
        checks++; if (buf_busy !== 1'b1) begin errors++;
            $display("FAIL b2b_f2_busy: got %b want 1", buf_busy); end
        run_frame(8, 0, -1);
        checks++; if (obs.size() != 16 || timeout != 0) begin errors++;
            $display("FAIL b2b_f2_count: got %0d want 16", obs.size()); end
        if (obs.size() > 0) begin
            w = obs[0];
            checks++; if (w[0 +: DW] !== 16'd100) begin errors++;
                $display("FAIL b2b_f2_w00: got %0d want 100", w[0 +: DW]); end
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i] !== expq[i]) begin errors++;
                $display("FAIL b2b_f2_win%0d: got %h want %h", i, obs[i], expq[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int n;
        for (int f = 0; f < 4; f++) begin
            n = (f == 3) ? MAXI : int'($urandom_range(12, 5));
            fill_rand(n);
            build_exp(n);
            start_frame(n);
            run_frame(n, 2, -1);
            checks++; if (obs.size() != expq.size() || timeout != 0) begin errors++;
                $display("FAIL rand%0d_count: got %0d want %0d (n=%0d)",
                    f, obs.size(), expq.size(), n); end
            checks++; if (gapviol != 0 || stray_done != 0) begin errors++;
                $display("FAIL rand%0d_gap_done: gapviol %0d stray %0d want 0 0",
                    f, gapviol, stray_done); end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                checks++;
                if (obs[i] !== expq[i]) begin errors++;
                    $display("FAIL rand%0d_win%0d: got %h want %h", f, i, obs[i], expq[i]); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_illegal();
        test_min();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
